fetch_prefetch_queue: RTL

//  Parametrised instruction fetch stage with a prefetch queue. Issues sequential PCs to an

---
 rtl/fetch_prefetch_queue_if.sv | 29 ++
 rtl/fetch_prefetch_queue.sv | 119 +++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch stage bus: execute redirect, imem request/response and decode handshake.
// master = fetch stage side, slave = surrounding pipeline/imem side.
interface fetch_prefetch_queue_if #(
  parameter int XLEN = 32
);
  logic            pc_select_execute;
  logic [XLEN-1:0] pc_target_execute;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] instruction_fetch;
  logic [XLEN-1:0] pc_fetch;
  logic [XLEN-1:0] next_pc_fetch;
  logic            fetch_fault;

  modport master (
    input  pc_select_execute, pc_target_execute, imem_rdata, fetch_ready,
    output imem_req, imem_addr, fetch_valid, instruction_fetch, pc_fetch,
           next_pc_fetch, fetch_fault
  );

  modport slave (
    output pc_select_execute, pc_target_execute, imem_rdata, fetch_ready,
    input  imem_req, imem_addr, fetch_valid, instruction_fetch, pc_fetch,
           next_pc_fetch, fetch_fault
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction fetch with a DEPTH-entry prefetch queue and execute redirect.
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirect targets halt fetch and present one fault entry.
module fetch_prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_prefetch_queue_if.master bus
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW:0]   DEPTH_L = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] q_instr [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            halted;
  logic            fault_pending;

  logic            redirect;
  logic            req;
  logic            push;
  logic            pop;
  logic            q_pop;
  logic            head_fault;
  logic            head_valid;
  logic [CW:0]     used;
  logic [XLEN-1:0] target_fpc;
  logic [XLEN-1:0] head_pc;

  assign redirect   = bus.pc_select_execute;
  // Credit check counts the in-flight response so a push can never overflow.
  assign used       = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign req        = rst & ~redirect & ~halted & (used < DEPTH_L);
  assign push       = rst & inflight & ~redirect;
  assign head_fault = fault_pending & (count == '0);
  assign head_valid = (count != '0) | head_fault;
  assign pop        = rst & head_valid & bus.fetch_ready & ~redirect;
  assign q_pop      = pop & (count != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      fpc      <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= req;
      if (req) begin
        fpc    <= fpc + XLEN'(4);
        req_pc <= fpc;
      end
      if (redirect) begin
        fpc    <= target_fpc;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (q_pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, q_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= req_pc;
      q_instr[wr_ptr] <= bus.imem_rdata;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic misaligned;
  assign misaligned = |bus.pc_target_execute[1:0];
  assign target_fpc = bus.pc_target_execute;

  // While halted no requests go out, so fpc still holds the faulting target.
  always_ff @(posedge clk) begin
    if (!rst) begin
      halted        <= 1'b0;
      fault_pending <= 1'b0;
    end else if (redirect) begin
      halted        <= misaligned;
      fault_pending <= misaligned;
    end else if (pop & head_fault) begin
      fault_pending <= 1'b0;
    end
  end
`else
  assign target_fpc    = bus.pc_target_execute & ~XLEN'(3);
  assign halted        = 1'b0;
  assign fault_pending = 1'b0;
`endif

  assign head_pc               = head_fault ? fpc : q_pc[rd_ptr];
  assign bus.imem_req          = req;
  assign bus.imem_addr         = rst ? fpc : RESET_PC;
  assign bus.fetch_valid       = rst & head_valid;
  assign bus.pc_fetch          = rst ? head_pc : '0;
  assign bus.next_pc_fetch     = rst ? head_pc + XLEN'(4) : '0;
  assign bus.instruction_fetch = (rst & ~head_fault) ? q_instr[rd_ptr] : '0;
  assign bus.fetch_fault       = rst & head_fault;

endmodule
